// File: rtl/arb4_grant_ctrl.sv
// arb4_grant_ctrl: four-requester arbiter with fixed-priority or round-robin
// selection, a registered one-hot grant, and a hold-time limit per grant.
module arb4_grant_ctrl #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_d;
  logic [3:0]    gnt_d;
  logic [1:0]    gnt_id_d;
  logic          gnt_vld_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    last, last_d;
  logic [1:0]    win_fix, win_rr, win, idx;
  logic          found;
  logic          rel;

  // Winner candidates: highest set index, and first set index after last (wrapping)
  always_comb begin
    win_fix = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) win_fix = 2'(i);
    end
    win_rr = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        win_rr = idx;
        found  = 1'b1;
      end
    end
    win = mode ? win_rr : win_fix;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    gnt_vld_d = gnt_vld;
    cnt_d     = cnt;
    last_d    = last;
    rel       = done || !req[gnt_id] || (cnt == HOLD_LAST);
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d   = GRANT;
          gnt_d     = 4'b0001 << win;
          gnt_id_d  = win;
          gnt_vld_d = 1'b1;
          last_d    = win;
          cnt_d     = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          gnt_vld_d = 1'b0;
        end else if (cnt != CNT_SAT) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = 4'b0000;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restarts round-robin from index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_id  <= 2'b00;
      gnt_vld <= 1'b0;
      cnt     <= '0;
      last    <= 2'd3;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      gnt_vld <= gnt_vld_d;
      cnt     <= cnt_d;
      last    <= last_d;
    end
  end

endmodule

// File: tb/tb_arb4_grant_ctrl.sv
// Self-checking bench for arb4_grant_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_arb4_grant_ctrl;

  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who owns the resource and for how many cycles so far
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;

  arb4_grant_ctrl #(.HOLD_MAX(HOLD), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_held  = 0;
    m_last  = 3;
  endfunction

  // One clock edge worth of arbitration rules
  function automatic void model_edge(logic [3:0] r, logic md, logic dn);
    int w;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        w = -1;
        if (md) begin
          for (int d = 1; d <= 4; d++)
            if (w < 0 && r[(m_last + d) % 4]) w = (m_last + d) % 4;
        end else begin
          for (int j = 3; j >= 0; j--)
            if (w < 0 && r[j]) w = j;
        end
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
        m_held  = 1;
      end
    end else begin
      if (dn || !r[m_owner] || m_held >= HOLD) m_busy = 1'b0;
      else m_held++;
    end
  endfunction

  // Advance one edge, update the model, compare outputs after the edge
  task automatic step();
    logic [3:0] eg;
    @(posedge clk);
    model_edge(req, mode, done);
    #1;
    eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
    chk("model_gnt", 8'(gnt), 8'(eg));
    chk("model_vld", 8'(gnt_vld), 8'(m_busy));
    if (m_busy) chk("model_id", 8'(gnt_id), 8'(m_owner));
  endtask

  task automatic go_idle();
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
  endtask

  initial begin
    int cnt_hi;
    logic [1:0] rr_exp [5];
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;

    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    done  = 1'b0;
    model_reset();
    #3;
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_vld", 8'(gnt_vld), 8'h00);
    chk("rst_id", 8'(gnt_id), 8'h00);
    #9 rst_n = 1'b1;

    // Fixed priority: 0110 -> index 2, done gives one idle cycle, then re-grant
    mode = 1'b0;
    req  = 4'b0110;
    step();
    chk("fix_gnt", 8'(gnt), 8'h04);
    chk("fix_id", 8'(gnt_id), 8'h02);
    done = 1'b1;
    step();
    chk("fix_rel", 8'(gnt), 8'h00);
    done = 1'b0;
    step();
    chk("fix_regnt", 8'(gnt), 8'h04);

    // Asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 8'(gnt), 8'h00);
    chk("arst_vld", 8'(gnt_vld), 8'h00);
    model_reset();
    #2 rst_n = 1'b1;

    // Round-robin from reset pointer: order 0,1,2,3,0 with an idle cycle between
    mode = 1'b1;
    req  = 4'b1111;
    step();
    chk("rr_first_gnt", 8'(gnt), 8'h01);
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", 8'(gnt_id), 8'(rr_exp[k]));
      done = 1'b1;
      step();
      chk("rr_gap", 8'(gnt), 8'h00);
      done = 1'b0;
      step();
    end
    go_idle();

    // Timeout: a held grant lasts exactly HOLD cycles, then one idle cycle
    mode = 1'b0;
    req  = 4'b1000;
    step();
    chk("to_gnt", 8'(gnt), 8'h08);
    cnt_hi = 1;
    for (int t = 0; t < 40 && gnt == 4'b1000; t++) begin
      step();
      if (gnt == 4'b1000) cnt_hi++;
    end
    chk("to_len", 8'(cnt_hi), 8'(HOLD));
    chk("to_gap", 8'(gnt), 8'h00);
    step();
    chk("to_regnt", 8'(gnt), 8'h08);
    go_idle();

    // No preemption by a higher index; owner drop releases
    req = 4'b0010;
    step();
    chk("np_gnt", 8'(gnt), 8'h02);
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("np_hold", 8'(gnt), 8'h02);
    end
    req = 4'b1000;
    step();
    chk("np_rel", 8'(gnt), 8'h00);
    step();
    chk("np_next", 8'(gnt), 8'h08);
    go_idle();

    // done in IDLE is ignored
    done = 1'b1;
    step();
    chk("idone_gnt", 8'(gnt), 8'h00);
    chk("idone_vld", 8'(gnt_vld), 8'h00);
    done = 1'b0;
    step();
    chk("idone_gnt2", 8'(gnt), 8'h00);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) mode = 1'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 5) == 0) req = 4'b0000;
      done = ($urandom_range(0, 9) == 0);
      step();
      chk("onehot", 8'($countones(gnt) <= 1), 8'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
